// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: frame scheduler for an 8-digit multiplexed seven-segment display.
// Each digit gets a slot of CLK_DIV cycles: an ON phase followed by BLANK_CYC
// all-off cycles. These all-off cycles stop the next digit from ghosting.
// The 32-bit value is latched only at frame boundaries (LOAD), so every frame
// shows one coherent value.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | display dark, waiting for enable
//   LOAD  | one cycle; snapshot value_in on request, compute lz_limit
//   ON    | anode for digit_idx driven (unless suppressed), hexVal valid
//   BLANK | all anodes off; advance to next digit or wrap to LOAD
module display_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        lz_en,
    input  logic [31:0] value_in,
    input  logic        value_req,
    output logic        value_ack,
    output logic [7:0]  anode,
    output logic [3:0]  hexVal,
    output logic [2:0]  digit_idx,
    output logic        frame_start
);

    localparam logic [19:0] ON_LAST  = 20'(CLK_DIV - BLANK_CYC - 1);
    localparam logic [19:0] BLK_LAST = 20'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ON    = 2'd2,
        BLANK = 2'd3
    } state_t;

    state_t      state;
    logic [19:0] prescaler;
    logic [31:0] shadow;
    logic [2:0]  lz_limit;

    logic [31:0] shadow_nxt;
    logic [2:0]  lz_nxt;
    logic [2:0]  digit_nxt;

    // Digits above lim are blanked for leading-zero suppression.
    function automatic logic [7:0] anode_for(input logic [2:0] idx, input logic [2:0] lim);
        return (idx <= lim) ? ~(8'd1 << idx) : 8'hFF;
    endfunction

    // Handshake, and the value and suppression limit that LOAD will commit.
    always_comb begin
        shadow_nxt = value_req ? value_in : shadow;
        lz_nxt     = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (shadow_nxt[4*i +: 4] != 4'd0) lz_nxt = 3'(i);
        end
        if (!lz_en) lz_nxt = 3'd7;
        digit_nxt   = digit_idx + 3'd1;
        // Gated by enable: a LOAD that is being aborted must not consume the request.
        value_ack   = (state == LOAD) && enable && value_req;
        frame_start = (state == LOAD);
    end

    // Scan FSM with registered anode/hexVal/digit_idx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            anode     <= 8'hFF;
            hexVal    <= 4'd0;
            digit_idx <= 3'd0;
            shadow    <= 32'd0;
            lz_limit  <= 3'd0;
            prescaler <= 20'd0;
        end else if (!enable) begin
            state     <= IDLE;
            anode     <= 8'hFF;
            digit_idx <= 3'd0;
            prescaler <= 20'd0;
        end else begin
            case (state)
                IDLE: begin
                    anode <= 8'hFF;
                    state <= LOAD;
                end
                LOAD: begin
                    shadow    <= shadow_nxt;
                    lz_limit  <= lz_nxt;
                    digit_idx <= 3'd0;
                    prescaler <= 20'd0;
                    anode     <= anode_for(3'd0, lz_nxt);
                    hexVal    <= shadow_nxt[3:0];
                    state     <= ON;
                end
                ON: begin
                    if (prescaler == ON_LAST) begin
                        prescaler <= 20'd0;
                        anode     <= 8'hFF;
                        state     <= BLANK;
                    end else begin
                        prescaler <= prescaler + 20'd1;
                    end
                end
                BLANK: begin
                    if (prescaler == BLK_LAST) begin
                        prescaler <= 20'd0;
                        if (digit_idx == 3'd7) begin
                            state <= LOAD;
                        end else begin
                            digit_idx <= digit_nxt;
                            anode     <= anode_for(digit_nxt, lz_limit);
                            hexVal    <= shadow[4*digit_nxt +: 4];
                            state     <= ON;
                        end
                    end else begin
                        prescaler <= prescaler + 20'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed test of display_scan_ctrl with CLK_DIV=10, BLANK_CYC=2.
module tb_display_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        lz_en;
    logic [31:0] value_in;
    logic        value_req;
    logic        value_ack;
    logic [7:0]  anode;
    logic [3:0]  hexVal;
    logic [2:0]  digit_idx;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    display_scan_ctrl #(.CLK_DIV(10), .BLANK_CYC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .lz_en       (lz_en),
        .value_in    (value_in),
        .value_req   (value_req),
        .value_ack   (value_ack),
        .anode       (anode),
        .hexVal      (hexVal),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    // 10-time-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at the LOAD-cycle negedge. Walks one frame (80 cycles) and checks
    // every cycle, then ends at the next LOAD. Optionally raises a request at
    // the start of slot req_digit.
    task automatic run_frame(input logic [31:0] shown, input logic [2:0] lim,
                             input int req_digit, input logic [31:0] req_val);
        logic [7:0] exp_an;
        logic [3:0] nib;
        for (int d = 0; d < 8; d++) begin
            nib    = shown[4*d +: 4];
            exp_an = (d <= int'(lim)) ? ~(8'd1 << d) : 8'hFF;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                check("anode", 32'(anode), 32'((c < 8) ? exp_an : 8'hFF));
                check("hexval", 32'(hexVal), 32'(nib));
                check("digit_idx", 32'(digit_idx), 32'(d));
                check("ack_midframe", 32'(value_ack), 32'd0);
                check("fstart_midframe", 32'(frame_start), 32'd0);
                if (d == req_digit && c == 0) begin
                    value_in  = req_val;
                    value_req = 1'b1;
                end
            end
        end
        @(negedge clk);
        check("fstart_wrap", 32'(frame_start), 32'd1);
    endtask

    initial begin
        rst       = 1'b0;
        enable    = 1'b0;
        lz_en     = 1'b0;
        value_req = 1'b0;
        value_in  = 32'd0;

        repeat (3) @(negedge clk);
        check("rst_anode", 32'(anode), 32'hFF);
        check("rst_hexval", 32'(hexVal), 32'd0);
        check("rst_digit", 32'(digit_idx), 32'd0);
        check("rst_ack", 32'(value_ack), 32'd0);
        check("rst_fstart", 32'(frame_start), 32'd0);

        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_anode", 32'(anode), 32'hFF);
            check("idle_ack", 32'(value_ack), 32'd0);
            check("idle_fstart", 32'(frame_start), 32'd0);
        end

        // Handshake at first LOAD; a request raised during digit 3 waits for next frame.
        value_in  = 32'h1234ABCD;
        value_req = 1'b1;
        enable    = 1'b1;
        @(negedge clk);
        check("load_fstart", 32'(frame_start), 32'd1);
        check("load_ack", 32'(value_ack), 32'd1);
        @(posedge clk); #1 value_req = 1'b0;
        run_frame(32'h1234ABCD, 3'd7, 3, 32'h0000_00FF);
        check("late_req_ack", 32'(value_ack), 32'd1);
        @(posedge clk); #1 value_req = 1'b0;
        run_frame(32'h0000_00FF, 3'd7, -1, 32'd0);
        check("no_req_ack", 32'(value_ack), 32'd0);

        // Leading-zero suppression.
        lz_en     = 1'b1;
        value_in  = 32'h0000_0F00;
        value_req = 1'b1;
        #1 check("lz_ack", 32'(value_ack), 32'd1);
        @(posedge clk); #1 value_req = 1'b0;
        run_frame(32'h0000_0F00, 3'd2, -1, 32'd0);

        value_in  = 32'd0;
        value_req = 1'b1;
        #1 check("zero_ack", 32'(value_ack), 32'd1);
        @(posedge clk); #1 value_req = 1'b0;
        run_frame(32'd0, 3'd0, -1, 32'd0);

        lz_en     = 1'b0;
        value_in  = 32'h0000_0F00;
        value_req = 1'b1;
        #1 check("nolz_ack", 32'(value_ack), 32'd1);
        @(posedge clk); #1 value_req = 1'b0;
        run_frame(32'h0000_0F00, 3'd7, -1, 32'd0);

        // Abort during the ON slot of digit 5, then restart.
        repeat (53) @(negedge clk);
        check("pre_abort_digit", 32'(digit_idx), 32'd5);
        check("pre_abort_anode", 32'(anode), 32'hDF);
        enable = 1'b0;
        @(negedge clk);
        check("abort_anode", 32'(anode), 32'hFF);
        check("abort_digit", 32'(digit_idx), 32'd0);
        check("abort_fstart", 32'(frame_start), 32'd0);
        @(negedge clk);
        check("abort_idle_anode", 32'(anode), 32'hFF);
        enable = 1'b1;
        @(negedge clk);
        check("reenable_fstart", 32'(frame_start), 32'd1);
        check("reenable_ack", 32'(value_ack), 32'd0);
        run_frame(32'h0000_0F00, 3'd7, -1, 32'd0);

        // Asynchronous reset during the BLANK of digit 2.
        repeat (29) @(negedge clk);
        check("blank_anode", 32'(anode), 32'hFF);
        check("blank_hexval", 32'(hexVal), 32'hF);
        check("blank_digit", 32'(digit_idx), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("arst_anode", 32'(anode), 32'hFF);
        check("arst_hexval", 32'(hexVal), 32'd0);
        check("arst_digit", 32'(digit_idx), 32'd0);
        check("arst_fstart", 32'(frame_start), 32'd0);
        lz_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_fstart", 32'(frame_start), 32'd1);
        run_frame(32'd0, 3'd0, -1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name:
display_scan_ctrl

Overview:
- Scheduler for the 8-digit multiplexed seven-segment datapath. It replaces the free-running digit rotation and the digit-select counter.
- Time-slices the display between 8 digits and inserts anode dead-time between digits to prevent ghosting.
- Snapshots the 32-bit display value only at frame boundaries, through a req/ack handshake with the value producer (counter), so every frame is coherent.
- Drives active-low anodes and the 4-bit nibble for the existing hex-to-seven-segment decoder, with optional leading-zero suppression.

Parameters:
- CLK_DIV, 50000, clock cycles per digit slot (ON + BLANK); legal range 2..2^20.
- BLANK_CYC, 1000, dead-time cycles at the end of each slot, all anodes off; 1 <= BLANK_CYC < CLK_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  scan enable; low forces the display dark
- lz_en  in  1  leading-zero suppression enable; sampled only in LOAD
- value_in  in  32  display value; nibble i goes to digit i, digit 0 = LSN on anode[0]
- value_req  in  1  producer requests an update; held high until value_ack
- value_ack  out  1  one-cycle pulse: value_in captured this cycle
- anode  out  8  active-low one-hot digit enable, registered
- hexVal  out  4  nibble of the digit being driven, registered
- digit_idx  out  3  index of the current slot
- frame_start  out  1  one-cycle pulse in LOAD

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state IDLE, anode 8'hFF, hexVal 0, digit_idx 0
  - shadow register 0, lz_limit 0
  - value_ack 0, frame_start 0, prescaler 0
- IDLE:
  - anode 8'hFF.
  - enable=1 -> LOAD on the next edge.
- LOAD (exactly 1 cycle):
  - frame_start=1.
  - If value_req=1: shadow <= value_in and value_ack=1 this cycle.
  - If value_req=0: shadow is kept and no ack is issued.
  - lz_limit <= index of the highest nonzero nibble of the new shadow (0 if the value is 0), or 7 if lz_en=0.
  - digit_idx <= 0, prescaler <= 0, then -> ON.
- ON (CLK_DIV-BLANK_CYC cycles):
  - anode = ~(8'b1 << digit_idx) if digit_idx <= lz_limit, else 8'hFF.
  - hexVal = shadow[4*digit_idx +: 4].
  - Outputs are registered and valid from the first ON cycle.
  - -> BLANK when the prescaler reaches CLK_DIV-BLANK_CYC-1.
- BLANK (BLANK_CYC cycles):
  - anode 8'hFF; hexVal holds its value.
  - On the last cycle: if digit_idx=7 -> LOAD (wrap); otherwise digit_idx+1 -> ON.
- Frame length is 8*CLK_DIV + 1 cycles.
- enable=0 in any non-IDLE state:
  - Next edge -> IDLE, anode 8'hFF, digit_idx 0, prescaler 0.
  - A pending value_req stays unacked.
- value_req asserted mid-frame is not acked until the next LOAD. The producer must hold value_in stable while req=1.
- value_ack is never asserted outside LOAD. At most one ack is issued per frame.
- Digit 0 is always displayed when enable=1, even for a value of 0 with lz_en=1.
- Glitch-free by construction: at most one anode bit is low at any time, and every digit change passes through at least BLANK_CYC all-off cycles.

Test Plan:
All scenarios use CLK_DIV=10 and BLANK_CYC=2.

- Reset/enable: hold rst=0, then release with enable=0 -> anode=FF, value_ack=0 indefinitely. Raise enable -> frame_start pulses 1 cycle later, then anode=FE for 8 cycles, FF for 2, FD for 8, and so on.
- Handshake: at LOAD, value_req=1 with value_in=32'h1234ABCD -> value_ack is a 1-cycle pulse in that same cycle. hexVal sequence over the frame is D,C,B,A,4,3,2,1, and frame period is 81 cycles.
- Mid-frame request: raise value_req with 32'h0000_00FF during digit 3 -> no ack until the next frame_start. The current frame still shows the old value; the next frame shows F,F,0,...
- Leading-zero suppression: lz_en=1, value 32'h0000_0F00 -> anodes FE, FD, FB are active and digits 3..7 stay FF. Value 0 -> only FE lights.
- lz_en=0 with value 32'h0000_0F00 -> all 8 anodes cycle in turn.
- Abort: drop enable during the ON slot of digit 5 -> next cycle anode=FF and state IDLE. Re-enable -> restarts at LOAD with digit 0. An asynchronous rst pulse mid-BLANK immediately sets all outputs to their reset values.
